booth_entry_sequencer: RTL and testbench
========================================

# booth_entry_sequencer

Keypad-driven sequencer for the signed 8×8 Booth multiplier calculator. It turns debounced key events into decimal operand entry for A and B, with sign and clear handling. It runs the start/done handshake with the Booth multiplier core and holds the 16-bit product for display. It sits between the keypad scanner/debouncer and the multiplier/display datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32: max cycles in WAIT before error (used only with watchdog compiled in).
- MAX_MAG, 127: largest accepted operand magnitude.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- key_valid  in  1  debounced key-present level from keypad.
- key_code  in  4  key: 0–9 digit, 0xA multiply, 0xB clear, 0xC sign toggle, 0xF equals; 0xD/0xE ignored.
- mult_done  in  1  one-cycle pulse from multiplier, product valid.
- mult_product  in  16  signed product, valid with mult_done.
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_a, mult_b  out  8  signed operands, two's complement.
- disp_value  out  16  signed value to display.
- result_valid  out  1  high while product shown.
- key_reject  out  1  one-cycle pulse: accepted key edge was illegal in current state.
- error  out  1  high in ERR.
- busy  out  1  high in START and WAIT.

## Operation
- Key event: key_valid high with previous-cycle key_valid low (internal edge detect). Key held high produces one event only.
- States: ENTRY_A, ENTRY_B, START, WAIT, SHOW, ERR. Reset state ENTRY_A.
- ENTRY_A/ENTRY_B:
  - Digit d: next = mag*10 + d, computed in 11 bits. Accept only if digit count < 3 and next <= MAX_MAG. Otherwise the digit is dropped and key_reject pulses.
  - 0xC toggles the operand's neg flag; allowed before any digit.
  - Operand value = neg ? -mag : mag. -0 is 0.
  - ENTRY_A, 0xA with >= 1 digit -> ENTRY_B (B cleared). 0xA with no digit -> key_reject.
  - ENTRY_B, 0xF with >= 1 digit -> START. 0xF with no digit -> key_reject. 0xA in ENTRY_B -> key_reject.
- START: mult_start = 1 for exactly this cycle -> WAIT.
- WAIT:
  - mult_done = 1 -> register mult_product -> SHOW.
  - All key events ignored, no reject pulse.
- SHOW:
  - result_valid = 1.
  - Digit -> clear A and B, enter digit as first digit of A -> ENTRY_A.
  - 0xB -> ENTRY_A cleared. Other keys -> key_reject.
- ERR: error = 1, disp_value = 0. Only 0xB leaves (-> ENTRY_A cleared); other keys ignored.
- 0xB in ENTRY_A/ENTRY_B clears mag, neg and digit count of both operands -> ENTRY_A.
- mult_a/mult_b are registered from operand state. They are stable from START until exit from WAIT.
- mult_done outside WAIT is ignored.
- disp_value:
  - ENTRY_A: sign-extended A.
  - ENTRY_B: sign-extended B.
  - START/WAIT: B.
  - SHOW: product.
  - ERR: 0.

## Timing
- Reset values: all outputs 0; state ENTRY_A; operands 0; previous key_valid 0.
- Reset asserted mid-WAIT aborts immediately. A later mult_done is ignored.
- Key edge sampled at edge n: operand, state, disp_value and key_reject all update at edge n; visible in cycle n+1.
- mult_start is high in the cycle after equals is sampled, for one cycle.
- Product captured on the edge where mult_done = 1. result_valid and disp_value update in the next cycle.
- Simultaneous key event and mult_done in WAIT: mult_done is taken, key dropped.
- Watchdog counter:
  - Clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without mult_done -> ERR.
  - mult_done on the same cycle as the count reaching TIMEOUT_CYCLES wins.

## Configuration
- BOOTH_SEQ_TIMEOUT_EN defined: watchdog counter present; WAIT times out to ERR as above.
- BOOTH_SEQ_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely until mult_done or reset. ERR is unreachable and error stays 0.

## Test plan
- Keys 1,2,0xC,0xA,5,0xC,0xF; multiplier model returns -60 after 8 cycles:
  - mult_a = 0x0C, mult_b = 0xFB.
  - Single mult_start pulse.
  - disp_value = 0xFFC4, result_valid = 1.
- Keys 1,2,8: third digit rejected (128 > 127), key_reject pulses once, disp_value = 12. Then 1,2,7 after 0xB gives 127.
- key_valid held high 20 cycles on digit 3 -> A = 3 only. 0xF in ENTRY_A and 0xA with no digit -> key_reject, state unchanged.
- With BOOTH_SEQ_TIMEOUT_EN, no mult_done: error rises after 32 WAIT cycles. Digit ignored; 0xB -> ENTRY_A with all outputs 0.
- Reset pulled low during WAIT, then mult_done pulse after release -> state ENTRY_A, result_valid = 0, no capture.
- From SHOW, press 4 -> ENTRY_A with A = 4, B = 0, result_valid = 0.

Source files
------------

// File: rtl/booth_entry_sequencer.sv
// Keypad-driven operand entry and start/done sequencing for the signed 8x8 Booth multiplier.
// Optional WAIT watchdog (timeout to ERR) is compiled in with `define BOOTH_SEQ_TIMEOUT_EN.
module booth_entry_sequencer #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int MAX_MAG        = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mult_done,
  input  logic [15:0] mult_product,
  output logic        mult_start,
  output logic [7:0]  mult_a,
  output logic [7:0]  mult_b,
  output logic [15:0] disp_value,
  output logic        result_valid,
  output logic        key_reject,
  output logic        error,
  output logic        busy
);

  localparam logic [2:0] ST_ENTRY_A = 3'd0;
  localparam logic [2:0] ST_ENTRY_B = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_SHOW    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  logic [2:0]  state_reg, state_next;
  logic        key_prev_reg;
  logic [7:0]  a_mag_reg, a_mag_next, b_mag_reg, b_mag_next;
  logic        a_neg_reg, a_neg_next, b_neg_reg, b_neg_next;
  logic [1:0]  a_cnt_reg, a_cnt_next, b_cnt_reg, b_cnt_next;
  logic [15:0] product_reg, product_next;
  logic [7:0]  mult_a_reg, mult_b_reg;
  logic        key_reject_reg, reject_next;
  logic        timeout_hit;

  logic        key_event, is_digit, in_b;
  logic [7:0]  cur_mag;
  logic [1:0]  cur_cnt;
  logic [10:0] digit_sum;
  logic        digit_ok;
  logic [7:0]  a_val, b_val, a_val_next, b_val_next;

  assign key_event = key_valid & ~key_prev_reg;
  assign is_digit  = (key_code <= 4'd9);
  assign in_b      = (state_reg == ST_ENTRY_B);
  assign cur_mag   = in_b ? b_mag_reg : a_mag_reg;
  assign cur_cnt   = in_b ? b_cnt_reg : a_cnt_reg;
  assign digit_sum = 11'(cur_mag) * 11'd10 + 11'(key_code);
  assign digit_ok  = (cur_cnt < 2'd3) && (digit_sum <= 11'(MAX_MAG));

  assign a_val      = a_neg_reg  ? -a_mag_reg  : a_mag_reg;
  assign b_val      = b_neg_reg  ? -b_mag_reg  : b_mag_reg;
  assign a_val_next = a_neg_next ? -a_mag_next : a_mag_next;
  assign b_val_next = b_neg_next ? -b_mag_next : b_mag_next;

  always_comb begin
    state_next   = state_reg;
    a_mag_next   = a_mag_reg;
    a_neg_next   = a_neg_reg;
    a_cnt_next   = a_cnt_reg;
    b_mag_next   = b_mag_reg;
    b_neg_next   = b_neg_reg;
    b_cnt_next   = b_cnt_reg;
    product_next = product_reg;
    reject_next  = 1'b0;
    case (state_reg)
      ST_ENTRY_A, ST_ENTRY_B: begin
        if (key_event) begin
          if (is_digit) begin
            if (!digit_ok) begin
              reject_next = 1'b1;
            end else if (in_b) begin
              b_mag_next = digit_sum[7:0];
              b_cnt_next = b_cnt_reg + 2'd1;
            end else begin
              a_mag_next = digit_sum[7:0];
              a_cnt_next = a_cnt_reg + 2'd1;
            end
          end else begin
            case (key_code)
              4'hA: begin
                if (!in_b && a_cnt_reg != 2'd0) begin
                  state_next = ST_ENTRY_B;
                  b_mag_next = 8'd0;
                  b_neg_next = 1'b0;
                  b_cnt_next = 2'd0;
                end else begin
                  reject_next = 1'b1;
                end
              end
              4'hB: begin
                state_next = ST_ENTRY_A;
                a_mag_next = 8'd0;  a_neg_next = 1'b0;  a_cnt_next = 2'd0;
                b_mag_next = 8'd0;  b_neg_next = 1'b0;  b_cnt_next = 2'd0;
              end
              4'hC: begin
                if (in_b) b_neg_next = ~b_neg_reg;
                else      a_neg_next = ~a_neg_reg;
              end
              4'hF: begin
                if (in_b && b_cnt_reg != 2'd0) state_next = ST_START;
                else                           reject_next = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        // Keys are deliberately dropped here; mult_done beats a simultaneous timeout.
        if (mult_done) begin
          product_next = mult_product;
          state_next   = ST_SHOW;
        end else if (timeout_hit) begin
          state_next = ST_ERR;
        end
      end
      ST_SHOW: begin
        if (key_event) begin
          if (is_digit || key_code == 4'hB) begin
            state_next = ST_ENTRY_A;
            a_mag_next = is_digit ? 8'(key_code) : 8'd0;
            a_neg_next = 1'b0;
            a_cnt_next = is_digit ? 2'd1 : 2'd0;
            b_mag_next = 8'd0;  b_neg_next = 1'b0;  b_cnt_next = 2'd0;
          end else if (key_code != 4'hD && key_code != 4'hE) begin
            reject_next = 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (key_event && key_code == 4'hB) begin
          state_next = ST_ENTRY_A;
          a_mag_next = 8'd0;  a_neg_next = 1'b0;  a_cnt_next = 2'd0;
          b_mag_next = 8'd0;  b_neg_next = 1'b0;  b_cnt_next = 2'd0;
        end
      end
      default: state_next = ST_ENTRY_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_ENTRY_A;
      key_prev_reg   <= 1'b0;
      a_mag_reg      <= 8'd0;
      a_neg_reg      <= 1'b0;
      a_cnt_reg      <= 2'd0;
      b_mag_reg      <= 8'd0;
      b_neg_reg      <= 1'b0;
      b_cnt_reg      <= 2'd0;
      product_reg    <= 16'd0;
      mult_a_reg     <= 8'd0;
      mult_b_reg     <= 8'd0;
      key_reject_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      key_prev_reg   <= key_valid;
      a_mag_reg      <= a_mag_next;
      a_neg_reg      <= a_neg_next;
      a_cnt_reg      <= a_cnt_next;
      b_mag_reg      <= b_mag_next;
      b_neg_reg      <= b_neg_next;
      b_cnt_reg      <= b_cnt_next;
      product_reg    <= product_next;
      key_reject_reg <= reject_next;
      // Operands freeze while the multiplier owns them.
      if (state_reg != ST_START && state_reg != ST_WAIT) begin
        mult_a_reg <= a_val_next;
        mult_b_reg <= b_val_next;
      end
    end
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  logic [15:0] wd_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       wd_reg <= 16'd0;
    else if (state_reg == ST_START) wd_reg <= 16'd0;
    else if (state_reg == ST_WAIT)  wd_reg <= wd_reg + 16'd1;
  end

  assign timeout_hit = (wd_reg + 16'd1 == 16'(TIMEOUT_CYCLES));
  assign error       = (state_reg == ST_ERR);
`else
  assign timeout_hit = 1'b0;
  // ERR cannot be reached without the watchdog; the parameter only folds away here.
  assign error       = (state_reg == ST_ERR) && (TIMEOUT_CYCLES < 0);
`endif

  assign mult_start   = (state_reg == ST_START);
  assign mult_a       = mult_a_reg;
  assign mult_b       = mult_b_reg;
  assign result_valid = (state_reg == ST_SHOW);
  assign key_reject   = key_reject_reg;
  assign busy         = (state_reg == ST_START) || (state_reg == ST_WAIT);

  always_comb begin
    case (state_reg)
      ST_ENTRY_A:                    disp_value = {{8{a_val[7]}}, a_val};
      ST_ENTRY_B, ST_START, ST_WAIT: disp_value = {{8{b_val[7]}}, b_val};
      ST_SHOW:                       disp_value = product_reg;
      default:                       disp_value = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_booth_entry_sequencer.sv
// Directed bench for booth_entry_sequencer: table of entry keystrokes plus
// hand sequences for multiply handshake, SHOW, held key, reset and WAIT timeout.
module tb_booth_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        mult_done = 1'b0;
  logic [15:0] mult_product = 16'h0;
  logic        mult_start;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] disp_value;
  logic        result_valid, key_reject, error, busy;

  booth_entry_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mult_done(mult_done), .mult_product(mult_product), .mult_start(mult_start),
    .mult_a(mult_a), .mult_b(mult_b), .disp_value(disp_value),
    .result_valid(result_valid), .key_reject(key_reject), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int start_cnt = 0;
  logic [7:0] start_a = 8'h0, start_b = 8'h0;

  always @(negedge clk) begin
    if (mult_start) begin
      start_cnt <= start_cnt + 1;
      start_a   <= mult_a;
      start_b   <= mult_b;
    end
  end

  typedef struct {
    logic [3:0]  key;
    logic        rej;
    logic [15:0] disp;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One key event: press for a cycle, release for a cycle; returns key_reject seen after the event edge.
  task automatic press(input logic [3:0] code, output logic rej);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk); #1;
    rej = key_reject;
    key_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic r;
    int   s0, nrej, n;

    vecs[0]  = '{4'h1, 1'b0, 16'h0001};
    vecs[1]  = '{4'h2, 1'b0, 16'h000C};
    vecs[2]  = '{4'h8, 1'b1, 16'h000C};
    vecs[3]  = '{4'hB, 1'b0, 16'h0000};
    vecs[4]  = '{4'h1, 1'b0, 16'h0001};
    vecs[5]  = '{4'h2, 1'b0, 16'h000C};
    vecs[6]  = '{4'h7, 1'b0, 16'h007F};
    vecs[7]  = '{4'h3, 1'b1, 16'h007F};
    vecs[8]  = '{4'hC, 1'b0, 16'hFF81};
    vecs[9]  = '{4'hF, 1'b1, 16'hFF81};
    vecs[10] = '{4'hA, 1'b0, 16'h0000};
    vecs[11] = '{4'hA, 1'b1, 16'h0000};
    vecs[12] = '{4'hF, 1'b1, 16'h0000};
    vecs[13] = '{4'hC, 1'b0, 16'h0000};
    vecs[14] = '{4'h0, 1'b0, 16'h0000};
    vecs[15] = '{4'h0, 1'b0, 16'h0000};
    vecs[16] = '{4'h9, 1'b0, 16'hFFF7};
    vecs[17] = '{4'h1, 1'b1, 16'hFFF7};
    vecs[18] = '{4'hD, 1'b0, 16'hFFF7};
    vecs[19] = '{4'hB, 1'b0, 16'h0000};

    // Reset state
    cycles(2);
    chk("rst_mult_start", 32'(mult_start), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_disp", 32'(disp_value), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_key_reject", 32'(key_reject), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    cycles(2);

    for (int i = 0; i < 20; i++) begin
      press(vecs[i].key, r);
      $display("vec %0d key=%h rej=%b disp=%h", i, vecs[i].key, r, disp_value);
      chk($sformatf("vec%0d_reject", i), 32'(r), 32'(vecs[i].rej));
      chk($sformatf("vec%0d_disp", i), 32'(disp_value), 32'(vecs[i].disp));
    end

    // 12 x -5 through the multiplier handshake
    s0 = start_cnt;
    press(4'h1, r); press(4'h2, r); press(4'hA, r);
    press(4'h5, r); press(4'hC, r); press(4'hF, r);
    chk("wait_busy", 32'(busy), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    mult_product = $signed(start_a) * $signed(start_b);
    mult_done = 1'b1;
    @(posedge clk); #1;
    mult_done = 1'b0;
    $display("mult a=%h b=%h product=%h disp=%h", start_a, start_b, mult_product, disp_value);
    chk("start_pulses", 32'(start_cnt - s0), 32'd1);
    chk("start_mult_a", 32'(start_a), 32'h0C);
    chk("start_mult_b", 32'(start_b), 32'hFB);
    chk("show_disp", 32'(disp_value), 32'hFFC4);
    chk("show_result_valid", 32'(result_valid), 32'd1);
    chk("show_busy", 32'(busy), 32'd0);
    chk("show_mult_a_held", 32'(mult_a), 32'h0C);

    // SHOW: non-digit rejected, digit starts a fresh A
    press(4'hC, r);
    $display("show key=C rej=%b", r);
    chk("show_sign_reject", 32'(r), 32'd1);
    chk("show_stays", 32'(result_valid), 32'd1);
    press(4'h4, r);
    $display("show key=4 rej=%b disp=%h", r, disp_value);
    chk("show_digit_reject", 32'(r), 32'd0);
    chk("show_digit_disp", 32'(disp_value), 32'h0004);
    chk("show_digit_rv", 32'(result_valid), 32'd0);
    press(4'hA, r);
    chk("show_digit_b_cleared", 32'(disp_value), 32'h0000);

    // Held key produces a single event
    press(4'hB, r);
    nrej = 0;
    key_valid = 1'b1;
    key_code  = 4'h3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (key_reject) nrej++;
    end
    key_valid = 1'b0;
    cycles(1);
    $display("held key=3 disp=%h rejects=%0d", disp_value, nrej);
    chk("held_disp", 32'(disp_value), 32'h0003);
    chk("held_rejects", 32'(nrej), 32'd0);
    press(4'hF, r);
    chk("equals_in_a_reject", 32'(r), 32'd1);
    chk("equals_in_a_disp", 32'(disp_value), 32'h0003);
    press(4'hB, r);
    press(4'hA, r);
    chk("mul_no_digit_reject", 32'(r), 32'd1);
    press(4'h7, r);
    chk("still_a_disp", 32'(disp_value), 32'h0007);
    press(4'hA, r);
    $display("A after reject rej=%b disp=%h", r, disp_value);
    chk("still_a_mul_ok", 32'(r), 32'd0);
    chk("still_a_mul_disp", 32'(disp_value), 32'h0000);

    // Reset during WAIT, late mult_done ignored
    press(4'h2, r); press(4'hF, r);
    cycles(3);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mult_product = 16'h1234;
    mult_done = 1'b1;
    @(posedge clk); #1;
    mult_done = 1'b0;
    cycles(1);
    $display("after reset rv=%b disp=%h busy=%b", result_valid, disp_value, busy);
    chk("late_done_rv", 32'(result_valid), 32'd0);
    chk("late_done_disp", 32'(disp_value), 32'h0000);
    chk("late_done_busy", 32'(busy), 32'd0);
    press(4'h5, r);
    chk("post_reset_entry", 32'(disp_value), 32'h0005);

    // 3 x 3 with no prompt mult_done
    press(4'hB, r); press(4'h3, r); press(4'hA, r); press(4'h3, r); press(4'hF, r);
`ifdef BOOTH_SEQ_TIMEOUT_EN
    n = 0;
    while (!error && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    $display("timeout after %0d cycles error=%b", n, error);
    chk("timeout_cycles", 32'(n), 32'd32);
    chk("err_disp", 32'(disp_value), 32'h0000);
    chk("err_busy", 32'(busy), 32'd0);
    press(4'h5, r);
    chk("err_digit_no_reject", 32'(r), 32'd0);
    chk("err_digit_stays", 32'(error), 32'd1);
    press(4'hB, r);
    chk("err_clear_error", 32'(error), 32'd0);
    chk("err_clear_disp", 32'(disp_value), 32'h0000);
    chk("err_clear_mult_a", 32'(mult_a), 32'h00);
    chk("err_clear_mult_b", 32'(mult_b), 32'h00);
    chk("err_clear_rv", 32'(result_valid), 32'd0);
    chk("err_clear_busy", 32'(busy), 32'd0);
    chk("err_clear_start", 32'(mult_start), 32'd0);
`else
    n = 40;
    cycles(n);
    $display("no watchdog: after %0d cycles busy=%b error=%b", n, busy, error);
    chk("nowd_error", 32'(error), 32'd0);
    chk("nowd_busy", 32'(busy), 32'd1);
    // key event and mult_done on the same edge: done wins, key dropped
    key_valid = 1'b1;
    key_code  = 4'hB;
    mult_product = 16'h0009;
    mult_done = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    mult_done = 1'b0;
    $display("simultaneous done+key rv=%b disp=%h rej=%b", result_valid, disp_value, key_reject);
    chk("simul_rv", 32'(result_valid), 32'd1);
    chk("simul_disp", 32'(disp_value), 32'h0009);
    chk("simul_reject", 32'(key_reject), 32'd0);
    cycles(1);
    press(4'hB, r);
    chk("show_clear_rv", 32'(result_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
